// File: rtl/dmx_pkg.sv
// Shared constants for the dmx_stream demultiplexer.
// Mode encodings and drop-counter sizing.
package dmx_pkg;

  localparam logic DMX_MODE_ADDR = 1'b0;
  localparam logic DMX_MODE_SCAN = 1'b1;

  localparam int DMX_CNT_W = 8;
  localparam logic [DMX_CNT_W-1:0] DMX_CNT_MAX = '1;

endpackage

// File: rtl/dmx_slot.sv
// One-entry output slot: load wins over drain, so back-to-back
// words flow without a bubble; data reads zero whenever empty.
module dmx_slot
  import dmx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && drain) begin
      valid <= 1'b0;
      q     <= '0;
    end
  end

endmodule

// File: rtl/dmx_stream.sv
// Registered valid/ready stream demux, one slot per channel.
// Optional saturating drop counter: define DMX_DROP_CNT_EN.
module dmx_stream
  import dmx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH_N   = 8,
  parameter int ADDR_W = $clog2(CH_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic [CH_N-1:0]        out_valid,
  input  logic [CH_N-1:0]        out_ready,
  output logic [CH_N*DATA_W-1:0] out_data,
  output logic                   err_addr,
`ifdef DMX_DROP_CNT_EN
  output logic [DMX_CNT_W-1:0]   drop_cnt,
`endif
  output logic [ADDR_W-1:0]      scan_ptr
);

  localparam int CH_P = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(CH_N - 1);

  logic [ADDR_W-1:0] sel;
  logic              sel_ok;
  logic [CH_P-1:0]   vpad;
  logic [CH_P-1:0]   rpad;
  logic              acc;
  logic [CH_N-1:0]   load;

  assign sel    = (mode == DMX_MODE_SCAN) ? scan_ptr : in_addr;
  assign sel_ok = int'(sel) < CH_N;

  // Pad to a power of two so an out-of-range sel never indexes past the end.
  assign vpad = CH_P'(out_valid);
  assign rpad = CH_P'(out_ready);

  assign in_ready = !sel_ok || !vpad[sel] || rpad[sel];
  assign acc      = in_valid && in_ready;

  for (genvar k = 0; k < CH_N; k++) begin : g_ch
    assign load[k] = acc && sel_ok && (int'(sel) == k);

    dmx_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .drain(out_ready[k]),
      .d    (in_data),
      .valid(out_valid[k]),
      .q    (out_data[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr <= '0;
      err_addr <= 1'b0;
    end else begin
      err_addr <= acc && !sel_ok;
      if (mode == DMX_MODE_ADDR) begin
        scan_ptr <= '0;
      end else if (acc) begin
        scan_ptr <= (scan_ptr == PTR_LAST) ? '0 : scan_ptr + ADDR_W'(1);
      end
    end
  end

`ifdef DMX_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (err_addr && drop_cnt != DMX_CNT_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmx_stream.sv
// Random + directed bench for dmx_stream (8- and 6-channel builds)
// against a per-channel slot reference model.
module tb_dmx_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic [7:0] ordy = '0;

  logic        rdy8, rdy6, err8, err6;
  logic [7:0]  ov8;
  logic [5:0]  ov6;
  logic [63:0] od8;
  logic [47:0] od6;
  logic [2:0]  sp8, sp6;
`ifdef DMX_DROP_CNT_EN
  logic [7:0]  dc8, dc6;
`endif

  int checks = 0;
  int failures = 0;

  bit         mf[2][8];
  logic [7:0] md[2][8];
  int         mp[2];
  bit         me[2];
  int         mc[2];

  always #5 clk = ~clk;

  dmx_stream #(.DATA_W(8), .CH_N(8)) u8 (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (rdy8),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_valid(ov8),
    .out_ready(ordy),
    .out_data (od8),
    .err_addr (err8),
`ifdef DMX_DROP_CNT_EN
    .drop_cnt (dc8),
`endif
    .scan_ptr (sp8)
  );

  dmx_stream #(.DATA_W(8), .CH_N(6)) u6 (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (rdy6),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_valid(ov6),
    .out_ready(ordy[5:0]),
    .out_data (od6),
    .err_addr (err6),
`ifdef DMX_DROP_CNT_EN
    .drop_cnt (dc6),
`endif
    .scan_ptr (sp6)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nch(input int i);
    return (i != 0) ? 6 : 8;
  endfunction

  function automatic int msel(input int i);
    return mode ? mp[i] : int'(in_addr);
  endfunction

  function automatic bit m_rdy(input int i);
    int s;
    s = msel(i);
    if (s >= nch(i)) return 1'b1;
    return !mf[i][s] || ordy[s];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        mf[i][k] = 1'b0;
        md[i][k] = '0;
      end
      mp[i] = 0;
      me[i] = 1'b0;
      mc[i] = 0;
    end
  endtask

  task automatic model_next();
    int s, n;
    bit ok, acc;
    for (int i = 0; i < 2; i++) begin
      n = nch(i);
      s = msel(i);
      ok = s < n;
      acc = in_valid && m_rdy(i);
      for (int k = 0; k < n; k++) begin
        if (acc && ok && s == k) begin
          mf[i][k] = 1'b1;
          md[i][k] = in_data;
        end else if (mf[i][k] && ordy[k]) begin
          mf[i][k] = 1'b0;
          md[i][k] = '0;
        end
      end
      if (me[i] && mc[i] < 255) mc[i]++;
      me[i] = acc && !ok;
      if (!mode) mp[i] = 0;
      else if (acc) mp[i] = (mp[i] + 1) % n;
    end
  endtask

  task automatic check_outs();
    logic [7:0]  ev[2];
    logic [63:0] ed[2];
    for (int i = 0; i < 2; i++) begin
      ev[i] = '0;
      ed[i] = '0;
      for (int k = 0; k < nch(i); k++) begin
        ev[i][k] = mf[i][k];
        ed[i][k*8 +: 8] = md[i][k];
      end
    end
    chk("out_valid8", 64'(ov8), 64'(ev[0]));
    chk("out_data8", od8, ed[0]);
    chk("scan_ptr8", 64'(sp8), 64'(mp[0]));
    chk("err_addr8", 64'(err8), 64'(me[0]));
    chk("out_valid6", 64'(ov6), 64'(ev[1]));
    chk("out_data6", 64'(od6), ed[1]);
    chk("scan_ptr6", 64'(sp6), 64'(mp[1]));
    chk("err_addr6", 64'(err6), 64'(me[1]));
`ifdef DMX_DROP_CNT_EN
    chk("drop_cnt8", 64'(dc8), 64'(mc[0]));
    chk("drop_cnt6", 64'(dc6), 64'(mc[1]));
`endif
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("in_ready8", 64'(rdy8), 64'(m_rdy(0)));
    chk("in_ready6", 64'(rdy6), 64'(m_rdy(1)));
    model_next();
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ov6_prev;
    reset_model();

    // reset with a pending word
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(ov8), 64'h0);
    chk("rst_data", od8, 64'h0);
    chk("rst_ready", 64'(rdy8), 64'h1);
    chk("rst_ptr", 64'(sp8), 64'h0);
    in_valid = 1'b0;
    @(negedge clk);

    // addressed load, then stall on a full slot
    mode = 1'b0; in_valid = 1'b1; in_addr = 3'd3;
    in_data = 8'hA5; ordy = 8'h00;
    step();
    chk("t2_valid", 64'(ov8), 64'h08);
    chk("t2_data", 64'(od8[31:24]), 64'hA5);
    in_data = 8'h5A;
    #1 chk("t2_stall", 64'(rdy8), 64'h0);
    step();
    step();
    chk("t2_hold", 64'(od8[31:24]), 64'hA5);
    ordy = 8'h08;
    step();
    chk("t2_next", 64'(od8[31:24]), 64'h5A);

    // same-cycle drain and reload
    ordy = 8'h00; in_addr = 3'd2; in_data = 8'h11;
    step();
    ordy = 8'h04; in_data = 8'h22;
    step();
    chk("t3_valid", 64'(ov8[2]), 64'h1);
    chk("t3_data", 64'(od8[23:16]), 64'h22);

    // drain everything, then scan ten words
    in_valid = 1'b0; ordy = 8'hFF;
    step();
    step();
    mode = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_data = 8'h30 + 8'(j);
      step();
      chk("t4_chan", 64'(ov8), 64'(8'h01 << (j % 8)));
    end
    chk("t4_ptr", 64'(sp8), 64'h2);

    // out-of-range drop on the 6-channel build
    mode = 1'b0; ordy = 8'h00; in_addr = 3'd7; in_data = 8'hEE;
    ov6_prev = ov6;
    step();
    chk("t5_err", 64'(err6), 64'h1);
    chk("t5_nochg", 64'(ov6), 64'(ov6_prev));
    in_valid = 1'b0;
    step();
    chk("t5_once", 64'(err6), 64'h0);
    in_valid = 1'b1; ordy = 8'hFF;
    for (int j = 0; j < 300; j++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
`ifdef DMX_DROP_CNT_EN
    chk("t5_sat", 64'(dc6), 64'd255);
`endif

    // async reset with three slots full
    mode = 1'b1; ordy = 8'h00; in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 8'hC0 + 8'(j);
      step();
    end
    chk("t6_full", 64'(ov8), 64'h07);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(ov8), 64'h0);
    chk("t6_data", od8, 64'h0);
    chk("t6_ptr", 64'(sp8), 64'h0);
    chk("t6_valid6", 64'(ov6), 64'h0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    mode = 1'b0;

    // randomized traffic
    for (int j = 0; j < 2000; j++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_addr = 3'($urandom);
      in_data = 8'($urandom);
      ordy = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
